// File: rtl/spike_fifo.sv
// Spike address FIFO between the LIF update engine and the spike output stage.
// Registered read data, sticky over/underflow flags and a saturating drop counter.
module spike_fifo #(
  parameter int M      = 8,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 8
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic                       clr_i,
  input  logic                       w_en_i,
  input  logic [M-1:0]               w_data_i,
  output logic                       full_o,
  input  logic                       r_en_i,
  output logic [M-1:0]               r_data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       overflow_o,
  output logic                       underflow_o,
  output logic [DROP_W-1:0]          drop_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Handshake: w_en_i/r_en_i are requests with no ready return. A write is taken
  // when not full or when a read is taken in the same cycle; a read is taken when
  // not empty and its data appears on r_data_o one cycle later. Refused requests
  // only raise the sticky flags (and, for writes, the drop counter).

  logic [M-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          rd_acc, wr_acc, wr_drop;

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;

  assign rd_acc  = r_en_i && !empty_o;
  assign wr_acc  = w_en_i && (!full_o || rd_acc);
  assign wr_drop = w_en_i && !wr_acc;

  // Storage is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (wr_acc && !clr_i) mem[wr_ptr] <= w_data_i;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      r_data_o    <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      drop_cnt_o  <= '0;
    end else if (clr_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      drop_cnt_o  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + 1'b1;
        r_data_o <= mem[rd_ptr];
      end
      if (wr_acc && !rd_acc)      count <= count + 1'b1;
      else if (rd_acc && !wr_acc) count <= count - 1'b1;
      if (r_en_i && empty_o) underflow_o <= 1'b1;
      if (wr_drop) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != {DROP_W{1'b1}}) drop_cnt_o <= drop_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: doc/spike_fifo.md
SPIKE_FIFO -- requirements
Module: spike_fifo

Interface
REQ-001 The block SHALL have parameter M, default 8, meaning spike address width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning entry count; the value SHALL be a power of two and at least 2.
REQ-003 The block SHALL have parameter DROP_W, default 8, meaning dropped-event counter width.
REQ-004 The block SHALL have port CLK, input, 1 bit, clock; all state changes on its rising edge.
REQ-005 The block SHALL have port RSTN, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port clr_i, input, 1 bit, synchronous flush of contents and flags.
REQ-007 The block SHALL have port w_en_i, input, 1 bit, write request from the LIF update engine.
REQ-008 The block SHALL have port w_data_i, input, M bits, neuron address of the spiking neuron.
REQ-009 The block SHALL have port full_o, output, 1 bit, high when count_o equals DEPTH.
REQ-010 The block SHALL have port r_en_i, input, 1 bit, read request from the spike output stage.
REQ-011 The block SHALL have port r_data_o, output, M bits, registered read data.
REQ-012 The block SHALL have port empty_o, output, 1 bit, high when count_o equals 0.
REQ-013 The block SHALL have port count_o, output, clog2(DEPTH+1) bits, current occupancy.
REQ-014 The block SHALL have port overflow_o, output, 1 bit, sticky flag: a write was dropped.
REQ-015 The block SHALL have port underflow_o, output, 1 bit, sticky flag: a read hit an empty FIFO.
REQ-016 The block SHALL have port drop_cnt_o, output, DROP_W bits, saturating count of dropped writes.

Function
REQ-017 Storage SHALL be DEPTH x M registers, with read and write pointers of clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-018 A write SHALL be accepted when w_en_i=1 and (full_o=0 or a read is accepted in the same cycle); w_data_i is stored at the write pointer and the write pointer advances by 1.
REQ-019 A read SHALL be accepted when r_en_i=1 and empty_o=0; on the next rising edge r_data_o loads the entry at the read pointer and the read pointer advances by 1.
REQ-020 Read latency SHALL be one cycle: data is valid the cycle after r_en_i is sampled, and r_data_o holds that value until the next accepted read.
REQ-021 Accepting both a read and a write in one cycle SHALL leave count_o unchanged, and both SHALL take effect; when full this stores the new entry in the freed slot.
REQ-022 With both requests high while empty, only the write SHALL be accepted, with no bypass to r_data_o; underflow_o SHALL be set.
REQ-023 w_en_i=1 with full_o=1 and no accepted read SHALL drop the data, leave pointers and count unchanged, set overflow_o, and increment drop_cnt_o, saturating at 2^DROP_W-1.
REQ-024 r_en_i=1 with empty_o=1 SHALL leave pointers and r_data_o unchanged and set underflow_o.
REQ-025 count_o SHALL equal accepted writes minus accepted reads since the last reset or clear, in the range 0..DEPTH; full_o and empty_o SHALL be decoded from registered count_o with no combinational path from w_en_i or r_en_i.
REQ-026 clr_i=1 SHALL take priority over same-cycle reads and writes: pointers, count_o, overflow_o, underflow_o and drop_cnt_o go to 0 and r_data_o holds.
REQ-027 Storage contents SHALL NOT be reset; the contents of unwritten entries are don't-care.

Reset
REQ-028 With RSTN=0, independent of CLK: pointers=0, count_o=0, empty_o=1, full_o=0, r_data_o=0, overflow_o=0, underflow_o=0, drop_cnt_o=0.
REQ-029 Reset asserted mid-operation SHALL discard all queued entries, and the first accepted write after release SHALL land at slot 0.

Verification
REQ-030 Test 1: after reset, write 0x11, 0x22, 0x33 in consecutive cycles, then read three times -> r_data_o = 0x11, 0x22, 0x33 one cycle after each r_en_i; empty_o=1 at the end.
REQ-031 Test 2: DEPTH=16, write 16 entries -> full_o=1, count_o=16; a 17th write -> dropped, overflow_o=1, drop_cnt_o=1; reads return the first 16 values in order.
REQ-032 Test 3: full FIFO, simultaneous read and write of 0xAA -> count_o stays 16, full_o stays 1; 0xAA is read out last.
REQ-033 Test 4: empty FIFO, simultaneous r_en_i and write of 0x5C -> count_o=1, underflow_o=1, r_data_o unchanged; the next read returns 0x5C.
REQ-034 Test 5: write and read 40 entries interleaved at DEPTH=16 -> pointers wrap with no data loss and no flags set; 300 writes into a full FIFO with DROP_W=8 -> drop_cnt_o=255.
REQ-035 Test 6: 5 entries queued, then pulse clr_i with w_en_i=1 in the same cycle -> count_o=0, empty_o=1, flags 0; assert RSTN=0 asynchronously between clocks -> all outputs at reset values immediately.
